// File: rtl/fp_alu_pkg.sv
// Shared definitions for the byte-serial FP ALU host sequencer: opcodes,
// host FSM states, byte counts and the operand byte-select helper.
package fp_alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;

    localparam int OPERAND_BYTES = 4;
    localparam int RESULT_BYTES  = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_COLLECT   = 3'd4,
        ST_RESP      = 3'd5
    } host_state_e;

    // ops is {B, A}; idx 0..7 walks A then B, least significant byte first.
    function automatic logic [7:0] operand_byte(input logic [63:0] ops, input logic [2:0] idx);
        return ops[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/fp_alu_host_wdog.sv
// WAIT_DONE watchdog for fp_alu_host; only instantiated when
// FP_ALU_HOST_TIMEOUT_EN is defined.
module fp_alu_host_wdog #(
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CW-1:0] count_q, count_d;

    // Restarts from 0 every time the host re-enters WAIT_DONE.
    always_comb begin
        count_d = '0;
        if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    assign expired = en && (count_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fp_alu_host.sv
// Host-side sequencer for the byte-serial FP ALU: parallel request in, byte
// stream out, four result bytes back in. Optional watchdog: FP_ALU_HOST_TIMEOUT_EN.
module fp_alu_host
    import fp_alu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [1:0]  req_opcode,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        resp_err,
    output logic        alu_start,
    output logic [1:0]  alu_opcode,
    output logic [7:0]  alu_in,
    input  logic [7:0]  alu_out,
    input  logic        alu_done,
    output logic        busy
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("fp_alu_host: TIMEOUT_CYCLES must be at least 1");
    end

    host_state_e state_q, state_d;
    logic [31:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [1:0]  op_q, op_d;
    logic        start_q, start_d;
    logic [7:0]  in_q, in_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        init_q, init_d;
    logic        accept;

`ifdef FP_ALU_HOST_TIMEOUT_EN
    logic err_q, err_d;
    logic wd_expired;

    fp_alu_host_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (state_q == ST_WAIT_DONE),
        .expired(wd_expired)
    );

    assign resp_err = err_q;
`else
    assign resp_err = 1'b0;
`endif

    // A response handshake and the next request may share one edge; that is
    // what allows a 16-cycle request period.
    assign req_ready   = init_q && ((state_q == ST_IDLE) || ((state_q == ST_RESP) && resp_ready));
    assign accept      = req_valid && req_ready;
    assign resp_valid  = (state_q == ST_RESP);
    assign resp_result = result_q;
    assign alu_start   = start_q;
    assign alu_opcode  = op_q;
    assign alu_in      = in_q;
    assign busy        = (state_q != ST_IDLE);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        start_d  = start_q;
        in_d     = in_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        init_d   = 1'b1;
`ifdef FP_ALU_HOST_TIMEOUT_EN
        err_d    = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
            end
            ST_START: begin
                start_d = 1'b0;
                in_d    = a_q[7:0];
                cnt_d   = 3'd0;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (cnt_q == 3'(2 * OPERAND_BYTES - 1)) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                    in_d  = operand_byte({b_q, a_q}, cnt_q + 3'd1);
                end
            end
            ST_WAIT_DONE: begin
                if (alu_done) begin
                    result_d[7:0] = alu_out;
                    cnt_d         = 3'd0;
                    state_d       = ST_COLLECT;
                end
`ifdef FP_ALU_HOST_TIMEOUT_EN
                else if (wd_expired) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = ST_RESP;
                end
`endif
            end
            ST_COLLECT: begin
                case (cnt_q)
                    3'd0:    result_d[15:8]  = alu_out;
                    3'd1:    result_d[23:16] = alu_out;
                    default: result_d[31:24] = alu_out;
                endcase
                if (cnt_q == 3'(RESULT_BYTES - 2)) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            a_d     = req_a;
            b_d     = req_b;
            op_d    = req_opcode;
            start_d = 1'b1;
            state_d = ST_START;
`ifdef FP_ALU_HOST_TIMEOUT_EN
            err_d   = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            start_q  <= 1'b0;
            in_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            init_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            start_q  <= start_d;
            in_q     <= in_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            init_q   <= init_d;
        end
    end

`ifdef FP_ALU_HOST_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_fp_alu_host.sv
// Bench for fp_alu_host: a behavioural byte-serial FP ALU responder, a
// scoreboard fed from accepted requests, and directed scenarios with literal results.
module tb_fp_alu_host;
  import fp_alu_pkg::*;

  localparam int TIMEOUT_CYCLES = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [1:0]  req_opcode;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_result;
  logic        resp_err;
  logic        alu_start;
  logic [1:0]  alu_opcode;
  logic [7:0]  alu_in;
  logic [7:0]  alu_out;
  logic        alu_done;
  logic        busy;

  fp_alu_host #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_opcode (req_opcode),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_result(resp_result),
    .resp_err   (resp_err),
    .alu_start  (alu_start),
    .alu_opcode (alu_opcode),
    .alu_in     (alu_in),
    .alu_out    (alu_out),
    .alu_done   (alu_done),
    .busy       (busy)
  );

  // ---------------- clock / reset bookkeeping ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rst_edges = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst_n) rst_edges = rst_edges + 1;
    else rst_edges = 0;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- floating-point reference ----------------
  function automatic real sp2r(input logic [31:0] x);
    logic [63:0] d;
    logic [10:0] e;
    if (x[30:0] == 31'd0) return 0.0;
    e = {3'b000, x[30:23]} + 11'd896;
    d = {x[31], e, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fp_calc(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    real ra, rb;
    ra = sp2r(a);
    rb = sp2r(b);
    if (op == OP_SUB) return r2sp(ra - rb);
    return r2sp(ra + rb);
  endfunction

  // ---------------- behavioural ALU responder ----------------
  // phase k is the negedge following host edge hk (h0 = the start pulse edge).
  logic        tie_done = 1'b0;
  int          phase = -1;
  logic [63:0] rx;
  logic [31:0] alu_res;
  logic [7:0]  rx_log [8];
  logic [1:0]  exp_op = 2'b00;

  always @(negedge clk) begin
    if (!rst_n) begin
      phase = -1;
      alu_done = 1'b0;
      alu_out = 8'hA5;
    end else begin
      if (alu_start) phase = 0;
      else if (phase >= 0) phase = phase + 1;
      if (phase >= 1 && phase <= 8) begin
        rx[(phase - 1) * 8 +: 8] = alu_in;
        rx_log[phase - 1] = alu_in;
      end
      if (phase == 11) begin
        check("alu_opcode_held", {62'd0, alu_opcode}, {62'd0, exp_op});
        alu_res = fp_calc(rx[31:0], rx[63:32], alu_opcode);
      end
      if (phase >= 11 && phase <= 14 && !tie_done) begin
        alu_done = 1'b1;
        alu_out = alu_res[(phase - 11) * 8 +: 8];
      end else begin
        alu_done = 1'b0;
        alu_out = 8'hA5;
      end
      if (phase >= 15 && !tie_done) phase = -1;
    end
  end

  // ---------------- scoreboard / compare process ----------------
  logic [32:0] exp_q [$];
  int          acc_q [$];
  logic        txn_open = 1'b0;
  logic        rv_prev = 1'b0;
  logic [32:0] last_resp = '0;
  int          resp_count = 0;
  int          last_acc = 0;
  int          prev_acc = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_q.delete();
      txn_open = 1'b0;
      rv_prev = 1'b0;
    end else begin
      check("busy", {63'd0, busy}, {63'd0, txn_open});
      if (rst_edges >= 1) begin
        if (!txn_open) check("req_ready_idle", {63'd0, req_ready}, 64'd1);
        else if (!resp_ready) check("req_ready_busy", {63'd0, req_ready}, 64'd0);
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", {63'd0, resp_valid}, 64'd0);
        end else begin
          check("resp_word", {31'd0, resp_err, resp_result}, {31'd0, exp_q[0]});
          if (!rv_prev && !tie_done && acc_q.size() > 0)
            check("latency", 64'(cyc - acc_q[0]), 64'd15);
        end
        if (resp_ready) begin
          last_resp = {resp_err, resp_result};
          resp_count = resp_count + 1;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          if (acc_q.size() > 0) void'(acc_q.pop_front());
          txn_open = 1'b0;
        end
      end
      rv_prev = resp_valid && !resp_ready;
      if (req_valid && req_ready) begin
`ifdef FP_ALU_HOST_TIMEOUT_EN
        if (tie_done) exp_q.push_back({1'b1, 32'd0});
        else exp_q.push_back({1'b0, fp_calc(req_a, req_b, req_opcode)});
`else
        exp_q.push_back({1'b0, fp_calc(req_a, req_b, req_opcode)});
`endif
        acc_q.push_back(cyc + 1);
        prev_acc = last_acc;
        last_acc = cyc + 1;
        exp_op = req_opcode;
        txn_open = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    bit ok;
    ok = 1'b0;
    req_a = a;
    req_b = b;
    req_opcode = op;
    req_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("req_accept_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int target);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (resp_count >= target) return;
    end
    check("resp_wait_timeout", 64'(resp_count), 64'(target));
  endtask

  task automatic check_all_zero();
    check("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_resp_result", {32'd0, resp_result}, 64'd0);
    check("rst_resp_err", {63'd0, resp_err}, 64'd0);
    check("rst_alu_start", {63'd0, alu_start}, 64'd0);
    check("rst_alu_opcode", {62'd0, alu_opcode}, 64'd0);
    check("rst_alu_in", {56'd0, alu_in}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
  endtask

  // ---------------- directed scenarios ----------------
  logic [7:0]  exp_bytes [8];
  logic [31:0] held;
  int          c0;

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_a = '0;
    req_b = '0;
    req_opcode = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero();
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Add 1.0 + 2.0
    c0 = resp_count;
    do_req(32'h3F800000, 32'h40000000, OP_ADD);
    wait_resp(c0 + 1);
    check("add_result", {31'd0, last_resp}, {31'd0, 1'b0, 32'h40400000});
    exp_bytes[0] = 8'h00; exp_bytes[1] = 8'h00; exp_bytes[2] = 8'h80; exp_bytes[3] = 8'h3F;
    exp_bytes[4] = 8'h00; exp_bytes[5] = 8'h00; exp_bytes[6] = 8'h00; exp_bytes[7] = 8'h40;
    for (int i = 0; i < 8; i++) check($sformatf("alu_in_byte%0d", i), {56'd0, rx_log[i]}, {56'd0, exp_bytes[i]});

    // Subtract 3.0 - 1.0
    @(posedge clk); #1;
    c0 = resp_count;
    do_req(32'h40400000, 32'h3F800000, OP_SUB);
    wait_resp(c0 + 1);
    check("sub_result", {31'd0, last_resp}, {31'd0, 1'b0, 32'h40000000});

    // Backpressure: 2.0 + 2.0 held for 10 cycles
    @(posedge clk); #1;
    resp_ready = 1'b0;
    c0 = resp_count;
    do_req(32'h40000000, 32'h40000000, OP_ADD);
    for (int i = 0; i < 40 && !resp_valid; i++) @(negedge clk);
    held = resp_result;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", {63'd0, resp_valid}, 64'd1);
      check("bp_req_ready", {63'd0, req_ready}, 64'd0);
      check("bp_stable", {32'd0, resp_result}, {32'd0, held});
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    wait_resp(c0 + 1);
    check("bp_result", {31'd0, last_resp}, {31'd0, 1'b0, 32'h40800000});

    // Back-to-back: 1.5 + 2.5, then 5.0 - 0.5
    @(posedge clk); #1;
    c0 = resp_count;
    do_req(32'h3FC00000, 32'h40200000, OP_ADD);
    do_req(32'h40A00000, 32'h3F000000, OP_SUB);
    wait_resp(c0 + 2);
    check("b2b_period", 64'(last_acc - prev_acc), 64'd16);
    check("b2b_result", {31'd0, last_resp}, {31'd0, 1'b0, 32'h40900000});

    // Reset while the fourth operand byte is on the bus
    @(posedge clk); #1;
    do_req(32'h40400000, 32'h3F800000, OP_SUB);
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_alu_in", {56'd0, alu_in}, 64'h40);
    rst_n = 1'b0;
    #1;
    check_all_zero();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    c0 = resp_count;
    do_req(32'h3F800000, 32'h3F800000, OP_ADD);
    wait_resp(c0 + 1);
    check("post_rst_result", {31'd0, last_resp}, {31'd0, 1'b0, 32'h40000000});

    // ALU never answers
    @(posedge clk); #1;
    tie_done = 1'b1;
    c0 = resp_count;
    do_req(32'h3F800000, 32'h3F800000, OP_ADD);
`ifdef FP_ALU_HOST_TIMEOUT_EN
    wait_resp(c0 + 1);
    check("timeout_resp", {31'd0, last_resp}, {31'd0, 1'b1, 32'h00000000});
`else
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("hang_resp_valid", {63'd0, resp_valid}, 64'd0);
      check("hang_busy", {63'd0, busy}, 64'd1);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
`endif
    tie_done = 1'b0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/fp_alu_host.md
# fp_alu_host

Host-side sequencer for the byte-serial floating-point ALU. It accepts a parallel request (two 32-bit IEEE-754 operands plus opcode) over a valid/ready handshake and drives the ALU's 8-bit operand bus and start strobe. It then collects the four result bytes framed by the ALU's `done` signal and returns a 32-bit result over a valid/ready response port. It sits between a parallel master (CPU bus or test harness) and the ALU core, on the same clock and reset.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 32: maximum cycles in WAIT_DONE before an error response. Only used with `FP_ALU_HOST_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock, shared with the ALU.
- `rst_n` in 1: reset, asynchronous, active-low; shared with the ALU.
- `req_valid` in 1; `req_ready` out 1: request handshake.
- `req_a`, `req_b` in 32: operands A and B.
- `req_opcode` in 2: operation code; 00 is add, 01 is subtract.
- `resp_valid` out 1; `resp_ready` in 1: response handshake.
- `resp_result` out 32: the result word.
- `resp_err` out 1: timeout flag. Constant 0 when the macro is absent.
- `alu_start` out 1: start strobe to the ALU.
- `alu_opcode` out 2: opcode to the ALU.
- `alu_in` out 8: ALU operand byte bus.
- `alu_out` in 8: ALU result byte bus.
- `alu_done` in 1: ALU done flag.
- `busy` out 1: high in every state except IDLE.

## Operation
- States:
  - IDLE: `req_ready`=1. On `req_valid`, latch A, B and opcode, set `alu_start`<=1, go to START.
  - START: `alu_start`<=0, `alu_in`<=A[7:0], byte counter <=0, go to SEND.
  - SEND: on each edge, increment the counter and drive the next byte: A[15:8], A[23:16], A[31:24], B[7:0] … B[31:24]. After B[31:24] has been driven for one cycle, go to WAIT_DONE.
  - WAIT_DONE: on the first edge that samples `alu_done`=1, capture `alu_out` into result[7:0] and go to COLLECT.
  - COLLECT: capture result[15:8], [23:16], [31:24] on the next three consecutive edges, then go to RESP.
  - RESP: `resp_valid`=1; hold `resp_result` and `resp_err` stable until `resp_ready`, then return to IDLE.
- Byte order is LSB first for both operands and the result.
- `alu_opcode` is driven from the latched opcode. It is held constant from START through COLLECT, because the ALU consumes it combinationally while executing.
- `alu_start` is a single-cycle pulse, asserted only while the ALU is idle.
- A new request cannot be accepted until RESP completes. This guarantees the previous `alu_done` has cleared before the next WAIT_DONE.
- Reset values: `req_ready`=0 while in reset and 1 after reset in IDLE. All other outputs, the latched operands and the result register reset to 0.
- Reset mid-operation: returns to IDLE immediately and any partial result is discarded. The ALU shares `rst_n`, so both ends resynchronise.
- The `req_valid` and `resp_ready` handshakes complete only on an edge where both signals of the pair are high.

## Timing
- Let h0 be the request-accept edge.
  - `alu_start`=1 during cycle h0..h1.
  - Operand byte n (n=0..7) is on `alu_in` from edge h(n+1) to h(n+2).
  - The ALU raises `done` after h11.
  - Result bytes are captured at h12, h13, h14 and h15.
  - `resp_valid` rises after h15.
- Latency from request accept to `resp_valid` is 15 cycles.
- Minimum period between accepted requests is 16 cycles, with `resp_ready` held at 1.

## Configuration
- `FP_ALU_HOST_TIMEOUT_EN` defined:
  - A watchdog counts cycles in WAIT_DONE from 0.
  - If it reaches `TIMEOUT_CYCLES` without sampling `alu_done`, the block goes to RESP with `resp_err`=1 and `resp_result`=0.
  - Once `done` is seen, COLLECT always completes.
- `FP_ALU_HOST_TIMEOUT_EN` undefined:
  - WAIT_DONE waits indefinitely.
  - `resp_err` is tied to 0.
  - No counter is synthesised.

## Structure
- Package `fp_alu_pkg` holds:
  - opcode constants `OP_ADD`=2'b00 and `OP_SUB`=2'b01;
  - the host state enum;
  - `OPERAND_BYTES`=4 and `RESULT_BYTES`=4.
- Sub-module `fp_alu_host_wdog` contains the timeout counter and is instantiated only under the macro. The main FSM stays in `fp_alu_host`.

## Test plan
- Add: A=0x3F800000 (1.0), B=0x40000000 (2.0), op=00.
  - Required: `alu_in` sequence 00,00,80,3F,00,00,00,40 on consecutive cycles.
  - Required: `resp_result`=0x40400000, `resp_valid` 15 cycles after accept.
- Subtract: A=0x40400000 (3.0), B=0x3F800000, op=01.
  - Required: `resp_result`=0x40000000 and `resp_err`=0.
- Backpressure: hold `resp_ready`=0 for 10 cycles.
  - Required: result held stable and `req_ready`=0 throughout.
  - Then two back-to-back requests complete 16 cycles apart.
- Reset mid-SEND: assert `rst_n`=0 after byte 3.
  - Required: all outputs read 0 during reset.
  - Then a fresh 1.0+1.0 request returns 0x40000000.
- Timeout (macro defined): tie `alu_done`=0.
  - Required: `resp_valid` with `resp_err`=1 and `resp_result`=0 after `TIMEOUT_CYCLES` in WAIT_DONE.
- Timeout (macro undefined): tie `alu_done`=0.
  - Required: `resp_valid` stays 0 for 100 cycles and `busy` stays 1.
